// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if -- control/status bundle between a test host and the
// core run controller.
//   master : the host side (issues start, relays core events, reads results)
//   slave  : the run controller itself
interface core_run_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   // host / core -> controller
   logic              i_Start;
   logic              i_Retire;
   logic              i_Halt;
   logic              i_TohostValid;
   logic [XLEN-1:0]   i_TohostData;

   // controller -> host / core
   logic              o_CoreReset;
   logic              o_Running;
   logic              o_Done;
   logic              o_Pass;
   logic              o_Timeout;
   logic [XLEN-2:0]   o_FailCode;
   logic [CNT_W-1:0]  o_CycleCount;
   logic [CNT_W-1:0]  o_RetireCount;

   modport master (
      output i_Start, i_Retire, i_Halt, i_TohostValid, i_TohostData,
      input  o_CoreReset, o_Running, o_Done, o_Pass, o_Timeout,
             o_FailCode, o_CycleCount, o_RetireCount
   );

   modport slave (
      input  i_Start, i_Retire, i_Halt, i_TohostValid, i_TohostData,
      output o_CoreReset, o_Running, o_Done, o_Pass, o_Timeout,
             o_FailCode, o_CycleCount, o_RetireCount
   );
endinterface

// File: rtl/core_run_ctrl.sv
// core_run_ctrl -- sequences one test run of a CPU core:
//   IDLE -> RESET (core held in reset for RESET_CYCLES) -> RUN -> DONE
// and records how the run ended (tohost pass/fail, timeout or halt),
// together with the number of cycles spent running and instructions retired.
//
// Optional feature macro: CORE_RUN_CTRL_RETIRE_CNT_EN
//   defined   : retire counter is built and reported on o_RetireCount
//   undefined : no retire counter, o_RetireCount is tied to 0, i_Retire unused
module core_run_ctrl #(
   parameter int XLEN         = 32,
   parameter int RESET_CYCLES = 2,
   parameter int MAX_CYCLES   = 50,
   parameter int CNT_W        = 16
) (
   input  logic          i_Clk,
   input  logic          i_Reset,   // asynchronous, active low
   core_run_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RESET = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TIMEOUT   = CNT_W'(MAX_CYCLES - 1);
   localparam logic [7:0]       RST_LAST      = 8'(RESET_CYCLES - 1);
   localparam logic [XLEN-1:0]  TOHOST_PASS   = XLEN'(1);

   state_t              state_q;
   logic [7:0]          rst_cnt_q;
   logic                core_reset_q;
   logic                pass_q;
   logic                timeout_q;
   logic [XLEN-2:0]     fail_code_q;
   logic [CNT_W-1:0]    cycle_q;
   logic [CNT_W-1:0]    cycle_d;
   logic [CNT_W-1:0]    retire_count;
   logic                start_accept;

   // A start request only matters from IDLE or DONE; it is dropped while a
   // run is being set up or is in progress.
   assign start_accept = bus.i_Start && ((state_q == S_IDLE) || (state_q == S_DONE));

   // Saturating next value of the run-cycle counter.
   assign cycle_d = (cycle_q == {CNT_W{1'b1}}) ? cycle_q : (cycle_q + CNT_ONE);

   // Run sequencer: state, core reset and result registers in one process.
   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         state_q      <= S_IDLE;
         rst_cnt_q    <= '0;
         core_reset_q <= 1'b0;
         pass_q       <= 1'b0;
         timeout_q    <= 1'b0;
         fail_code_q  <= '0;
         cycle_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_accept) begin
                  // Fresh run: clear all results from the previous one.
                  state_q      <= S_RESET;
                  rst_cnt_q    <= '0;
                  core_reset_q <= 1'b0;
                  pass_q       <= 1'b0;
                  timeout_q    <= 1'b0;
                  fail_code_q  <= '0;
                  cycle_q      <= '0;
               end
            end

            S_RESET: begin
               if (rst_cnt_q == RST_LAST) begin
                  state_q      <= S_RUN;
                  core_reset_q <= 1'b1;
               end else begin
                  rst_cnt_q    <= rst_cnt_q + 8'd1;
               end
            end

            S_RUN: begin
               // The terminating cycle is still a counted run cycle.
               cycle_q <= cycle_d;
               if (bus.i_TohostValid) begin
                  state_q <= S_DONE;
                  if (bus.i_TohostData == TOHOST_PASS) begin
                     pass_q      <= 1'b1;
                     fail_code_q <= '0;
                  end else begin
                     pass_q      <= 1'b0;
                     fail_code_q <= bus.i_TohostData[XLEN-1:1];
                  end
               end else if (cycle_q == CNT_TIMEOUT) begin
                  state_q   <= S_DONE;
                  timeout_q <= 1'b1;
               end else if (bus.i_Halt) begin
                  // Halt without a tohost verdict is reported as a plain fail.
                  state_q     <= S_DONE;
                  pass_q      <= 1'b0;
                  timeout_q   <= 1'b0;
                  fail_code_q <= '0;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef CORE_RUN_CTRL_RETIRE_CNT_EN
   logic [CNT_W-1:0] retire_q;

   // Retired-instruction counter: cleared with each new run, counts only in RUN.
   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         retire_q <= '0;
      end else if (start_accept) begin
         retire_q <= '0;
      end else if ((state_q == S_RUN) && bus.i_Retire && (retire_q != {CNT_W{1'b1}})) begin
         retire_q <= retire_q + CNT_ONE;
      end
   end

   assign retire_count = retire_q;
`else
   logic unused_retire;

   assign unused_retire = bus.i_Retire;
   assign retire_count  = '0;
`endif

   // Status flags are decoded directly from the state register.
   assign bus.o_Running     = (state_q == S_RUN);
   assign bus.o_Done        = (state_q == S_DONE);
   assign bus.o_CoreReset   = core_reset_q;
   assign bus.o_Pass        = pass_q;
   assign bus.o_Timeout     = timeout_q;
   assign bus.o_FailCode    = fail_code_q;
   assign bus.o_CycleCount  = cycle_q;
   assign bus.o_RetireCount = retire_count;

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 Parameter XLEN, 32, width of the tohost data word.
REQ-002 Parameter RESET_CYCLES, 2, number of cycles o_CoreReset is held low after start (range 1..255).
REQ-003 Parameter MAX_CYCLES, 50, run-cycle budget before timeout (range 1..2^CNT_W-1).
REQ-004 Parameter CNT_W, 16, width of the cycle and retire counters.
REQ-005 i_Clk  in  1  single clock; all state changes on the rising edge.
REQ-006 i_Reset  in  1  asynchronous, active-low reset.
REQ-007 i_Start  in  1  one-cycle request to (re)start a run.
REQ-008 i_Retire  in  1  core retired one instruction this cycle.
REQ-009 i_Halt  in  1  core reached a halt instruction (ebreak/ecall).
REQ-010 i_TohostValid  in  1  core wrote the tohost word this cycle.
REQ-011 i_TohostData  in  XLEN  tohost word.
REQ-012 o_CoreReset  out  1  active-low reset to the core.
REQ-013 o_Running  out  1  high in RUN.
REQ-014 o_Done  out  1  high in DONE.
REQ-015 o_Pass  out  1  run ended with tohost == 1.
REQ-016 o_Timeout  out  1  run ended by exhausting MAX_CYCLES.
REQ-017 o_FailCode  out  XLEN-1  i_TohostData[XLEN-1:1] captured on a failing tohost write.
REQ-018 o_CycleCount  out  CNT_W  cycles spent in RUN.
REQ-019 o_RetireCount  out  CNT_W  instructions retired in RUN.

Function
REQ-020 FSM states IDLE, RESET, RUN, DONE; the state register SHALL be the only source of o_Running/o_Done.
REQ-021 IDLE->RESET on i_Start; RESET->RUN after exactly RESET_CYCLES cycles in RESET; RUN->DONE on a termination event; DONE->RESET on i_Start.
REQ-022 o_CoreReset SHALL be 0 in IDLE and RESET, 1 in RUN and DONE, registered (no combinational path from inputs).
REQ-023 Entering RESET SHALL clear o_CycleCount, o_RetireCount, o_Pass, o_Timeout and o_FailCode.
REQ-024 In RUN, o_CycleCount SHALL increment by 1 every cycle; o_RetireCount SHALL increment on each i_Retire; both saturate at all-ones.
REQ-025 Termination priority in one cycle: tohost > timeout > halt.
REQ-026 i_TohostValid with data == 1 -> DONE, o_Pass = 1; with data != 1 -> DONE, o_Pass = 0, o_FailCode = data >> 1.
REQ-027 Timeout: when o_CycleCount == MAX_CYCLES-1 in RUN and no tohost write, next state DONE with o_Timeout = 1.
REQ-028 i_Halt in RUN without higher-priority event -> DONE, o_Pass = 0, o_Timeout = 0, o_FailCode = 0.
REQ-029 The cycle in which termination is detected SHALL still be counted (i_Retire included).
REQ-030 i_Start in RESET or RUN SHALL be ignored; i_Retire/i_Halt/i_TohostValid outside RUN SHALL be ignored.
REQ-031 In DONE all result outputs and counters SHALL hold until the next i_Start.

Reset
REQ-032 i_Reset = 0 SHALL asynchronously force state IDLE, o_CoreReset = 0, all other outputs and counters 0, regardless of state (including mid-RUN).
REQ-033 After i_Reset deasserts, the block SHALL remain in IDLE until i_Start.

Configuration
REQ-034 Macro CORE_RUN_CTRL_RETIRE_CNT_EN: when defined, the retire counter is built per REQ-024; when undefined, no retire counter register exists, o_RetireCount is constant 0, i_Retire is unused; all other behaviour identical.

Verification
REQ-035 Reset release, i_Start pulse at cycle 3 -> o_CoreReset low for exactly 2 cycles, then high with o_Running = 1.
REQ-036 Run, i_Retire every cycle, i_TohostValid with data 1 on run cycle 20 -> o_Done, o_Pass = 1, o_CycleCount = 20, o_RetireCount = 20 (0 if macro undefined).
REQ-037 Run, tohost data 0x0000_0007 -> o_Pass = 0, o_FailCode = 3.
REQ-038 Run with no events, MAX_CYCLES = 50 -> o_Timeout = 1 after exactly 50 RUN cycles, o_CycleCount = 50; i_Halt plus tohost data 1 in the same cycle -> o_Pass = 1.
REQ-039 i_Reset pulled low mid-RUN at cycle 10 -> immediate IDLE, outputs 0; subsequent i_Start in DONE restarts with cleared counters.
